mem_stage_ws: RTL and testbench
===============================

# mem_stage_ws

Parametrised memory stage for the ARM-style five-stage pipeline. It sits between the EXE/MEM boundary and the WB stage and contains the data memory array. Memory accesses take a configurable number of wait states, and the stage stalls the upstream pipeline while an access is in flight. The MEM/WB pipeline register is built in and inserts bubbles during stalls.

## Interface

Parameters:
- DATA_W, 32, data word width.
- ADDR_W, 32, address width on aluResIn.
- REG_W, 4, destination register index width.
- DEPTH, 64, number of memory words; power of two.
- WAIT_CYCLES, 2, extra cycles per memory access; 0 gives single-cycle access.
- BASE_ADDR, 1024, byte address mapped to word 0.

Ports:
- clk  in  1  single clock; all state changes on rising edge.
- rst  in  1  asynchronous, active-low reset.
- wbEnIn  in  1  instruction writes back.
- memREnIn  in  1  load.
- memWEnIn  in  1  store.
- aluResIn  in  ADDR_W  address for memory ops; result for ALU ops.
- valRm  in  DATA_W  store data.
- destIn  in  REG_W  destination register.
- stall  out  1  combinational; upstream must freeze while high.
- wbEnOut  out  1  registered.
- memREnOut  out  1  registered.
- aluResOut  out  ADDR_W  registered.
- memOut  out  DATA_W  registered load data.
- destOut  out  REG_W  registered.
- alignErr  out  1  registered one-cycle pulse on a misaligned memory op.

## Operation

- Word index = ((aluResIn − BASE_ADDR) >> 2) modulo DEPTH (low log2(DEPTH) bits). Out-of-range addresses wrap; they are not trapped.
- Address bits [1:0] are ignored for indexing. If they are non-zero on a memory op, alignErr is set on the completion edge.
- memOp = memREnIn | memWEnIn. If both are high, the op is a store, and memOut receives the pre-write word.
- FSM states:
  - IDLE:
    - memOp && WAIT_CYCLES>0: latch inputs, cnt <= WAIT_CYCLES−1, go to WAIT.
    - memOp && WAIT_CYCLES==0: complete immediately.
    - Non-memOp: pass through.
  - WAIT:
    - cnt != 0: cnt decrements.
    - cnt == 0: complete the latched op, return to IDLE.
- stall = (IDLE && memOp && WAIT_CYCLES>0) || (WAIT && cnt!=0).
- Completion edge:
  - A store writes the latched valRm into the latched index.
  - A load registers mem[index] into memOut.
  - The MEM/WB register captures the latched wbEn/memREn/aluRes/dest.
- A non-memory op loads the MEM/WB register the cycle it is presented. memOut holds its previous value.
- On every edge where stall=1, the MEM/WB register takes a bubble: wbEnOut=0, memREnOut=0, alignErr=0. aluResOut, destOut and memOut hold.
- Input changes during WAIT are ignored; the latched copy is used.

## Timing

- Op presented in cycle T with WAIT_CYCLES=N:
  - stall is high in cycles T..T+N−1 and low in T+N.
  - The op completes at the end of T+N; outputs are valid in T+N+1.
  - Latency is N+1 edges.
- Back-to-back memory ops: the next op is accepted in IDLE at T+N+1, so there are no dead cycles between them.
- WAIT_CYCLES=0: stall is constant 0 and every op has a one-edge latency.
- Reset (rst=0, asynchronous):
  - state=IDLE, cnt=0, and all registered outputs are 0.
  - stall=0 while rst is low.
  - The memory array is cleared to 0.
- Reset mid-WAIT aborts the op. The store is not committed.
- Reset release: the first op can be accepted on the first edge with rst=1.

## Test plan

All scenarios use the default parameters unless stated.

1. Reset mid-store:
   - Stimulus: store 0x12345678 to 1028; assert rst=0 in the second stall cycle, release, then load 1028.
   - Required: all outputs 0 during reset; the load returns memOut=0.
2. Store/load:
   - Stimulus: store 0xDEADBEEF at 1032, then load 1032 with destIn=5, wbEnIn=1.
   - Required: stall is high exactly 2 cycles per op; for the load, memOut=0xDEADBEEF, destOut=5, wbEnOut=1 three edges after presentation.
   - Required: bubbles (wbEnOut=0) appear while stall is high.
3. ALU pass-through:
   - Stimulus: memOp=0, aluResIn=0x55, destIn=3, wbEnIn=1.
   - Required: the next cycle shows aluResOut=0x55, destOut=3, wbEnOut=1; stall is never high.
4. Wrap-around:
   - Stimulus: store 0xA5A5A5A5 at 1280 (1024+64·4), then load 1024.
   - Required: memOut=0xA5A5A5A5.
5. Misaligned access and dual enable:
   - Stimulus A: load at 1026.
   - Required A: alignErr pulses once, and word 0 is returned.
   - Stimulus B: memREnIn=memWEnIn=1 with valRm=7 at 1024.
   - Required B: memOut shows the prior word, and a subsequent load returns 7.
6. WAIT_CYCLES=0 build:
   - Stimulus: three back-to-back loads from 1024/1028/1032.
   - Required: stall stays 0, and memOut updates on three consecutive edges.

Source files
------------

// File: rtl/mem_stage_ws.sv
// mem_stage_ws
//   Memory stage of a five-stage pipeline with a built-in data memory and
//   the MEM/WB pipeline register. Every memory access takes WAIT_CYCLES
//   extra cycles; the upstream pipeline is frozen through `stall` while an
//   access is in flight, and the MEM/WB register emits bubbles meanwhile.
//
// Ports
//   clk        rising-edge clock
//   rst        asynchronous active-low reset (also clears the memory)
//   wbEnIn     instruction writes back
//   memREnIn   load
//   memWEnIn   store (wins over load when both are set)
//   aluResIn   byte address for memory ops, ALU result otherwise
//   valRm      store data
//   destIn     destination register index
//   stall      combinational; upstream holds its state while high
//   wbEnOut    MEM/WB write-back enable
//   memREnOut  MEM/WB load flag
//   aluResOut  MEM/WB ALU result / address
//   memOut     load data (pre-write word for a load+store op)
//   destOut    MEM/WB destination register
//   alignErr   one-cycle pulse when a completed memory op had addr[1:0]!=0
module mem_stage_ws #(
    parameter int DATA_W      = 32,
    parameter int ADDR_W      = 32,
    parameter int REG_W       = 4,
    parameter int DEPTH       = 64,
    parameter int WAIT_CYCLES = 2,
    parameter int BASE_ADDR   = 1024
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              wbEnIn,
    input  logic              memREnIn,
    input  logic              memWEnIn,
    input  logic [ADDR_W-1:0] aluResIn,
    input  logic [DATA_W-1:0] valRm,
    input  logic [REG_W-1:0]  destIn,
    output logic              stall,
    output logic              wbEnOut,
    output logic              memREnOut,
    output logic [ADDR_W-1:0] aluResOut,
    output logic [DATA_W-1:0] memOut,
    output logic [REG_W-1:0]  destOut,
    output logic              alignErr
);

    localparam int IDX_W = $clog2(DEPTH);
    // The counter only ever holds WAIT_CYCLES-1.
    localparam int CNT_W = (WAIT_CYCLES > 1) ? $clog2(WAIT_CYCLES) : 1;
    localparam logic [CNT_W-1:0]  CNT_INIT = (WAIT_CYCLES > 0) ? CNT_W'(WAIT_CYCLES - 1) : '0;
    localparam logic [ADDR_W-1:0] BASE     = ADDR_W'(BASE_ADDR);
    localparam bit                HAS_WAIT = (WAIT_CYCLES > 0);

    typedef enum logic {S_IDLE, S_WAIT} state_t;

    state_t            state, state_next;
    logic [CNT_W-1:0]  cnt;
    logic              accept, complete, pass;
    logic              mem_op;

    logic              lat_wb, lat_mr, lat_mw;
    logic [ADDR_W-1:0] lat_alu;
    logic [DATA_W-1:0] lat_val;
    logic [REG_W-1:0]  lat_dest;

    logic              op_wb, op_mr, op_mw;
    logic [ADDR_W-1:0] op_alu, op_off;
    logic [DATA_W-1:0] op_val, rd_word;
    logic [REG_W-1:0]  op_dest;
    logic [IDX_W-1:0]  op_idx;

    logic [DATA_W-1:0] mem [DEPTH];

    assign mem_op = memREnIn | memWEnIn;

    // In WAIT the op being completed is the latched copy; in IDLE (only
    // relevant when there are no wait states) it is the live input.
    always_comb begin
        if (state == S_WAIT) begin
            op_wb   = lat_wb;
            op_mr   = lat_mr;
            op_mw   = lat_mw;
            op_alu  = lat_alu;
            op_val  = lat_val;
            op_dest = lat_dest;
        end else begin
            op_wb   = wbEnIn;
            op_mr   = memREnIn;
            op_mw   = memWEnIn;
            op_alu  = aluResIn;
            op_val  = valRm;
            op_dest = destIn;
        end
        // Byte offset from the base, word-indexed; high bits drop so
        // out-of-range addresses wrap around the array.
        op_off  = op_alu - BASE;
        op_idx  = IDX_W'(op_off >> 2);
        rd_word = mem[op_idx];
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) state <= S_IDLE;
        else      state <= state_next;
    end

    always_comb begin
        state_next = state;
        case (state)
            S_IDLE:  if (mem_op && HAS_WAIT) state_next = S_WAIT;
            S_WAIT:  if (cnt == '0)          state_next = S_IDLE;
            default: state_next = S_IDLE;
        endcase
    end

    always_comb begin
        stall    = 1'b0;
        accept   = 1'b0;
        complete = 1'b0;
        pass     = 1'b0;
        case (state)
            S_IDLE: begin
                if (mem_op) begin
                    if (HAS_WAIT) begin
                        stall  = 1'b1;
                        accept = 1'b1;
                    end else begin
                        complete = 1'b1;
                    end
                end else begin
                    pass = 1'b1;
                end
            end
            S_WAIT: begin
                if (cnt != '0) stall    = 1'b1;
                else           complete = 1'b1;
            end
            default: ;
        endcase
        if (!rst) stall = 1'b0;
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            cnt <= '0;
        end else if (accept) begin
            cnt <= CNT_INIT;
        end else if (state == S_WAIT && cnt != '0) begin
            cnt <= cnt - CNT_W'(1);
        end
    end

    // Held copy of the accepted op; inputs are ignored while in WAIT.
    always_ff @(posedge clk) begin
        if (accept) begin
            lat_wb   <= wbEnIn;
            lat_mr   <= memREnIn;
            lat_mw   <= memWEnIn;
            lat_alu  <= aluResIn;
            lat_val  <= valRm;
            lat_dest <= destIn;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
        end else if (complete && op_mw) begin
            mem[op_idx] <= op_val;
        end
    end

    // MEM/WB register: bubble while stalled, completed op, or ALU pass-through.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            wbEnOut   <= 1'b0;
            memREnOut <= 1'b0;
            aluResOut <= '0;
            memOut    <= '0;
            destOut   <= '0;
            alignErr  <= 1'b0;
        end else if (stall) begin
            wbEnOut   <= 1'b0;
            memREnOut <= 1'b0;
            alignErr  <= 1'b0;
        end else if (complete) begin
            wbEnOut   <= op_wb;
            memREnOut <= op_mr;
            aluResOut <= op_alu;
            destOut   <= op_dest;
            alignErr  <= (op_alu[1:0] != 2'b00);
            if (op_mr) memOut <= rd_word;
        end else if (pass) begin
            wbEnOut   <= wbEnIn;
            memREnOut <= memREnIn;
            aluResOut <= aluResIn;
            destOut   <= destIn;
            alignErr  <= 1'b0;
        end
    end

endmodule

// File: tb/tb_mem_stage_ws.sv
module tb_mem_stage_ws;

    logic        clk = 1'b0;
    logic        rst;
    logic        wb, mr, mw;
    logic [31:0] alu, val;
    logic [3:0]  dest;
    logic        stall, wb_o, mr_o, ae_o;
    logic [31:0] alu_o, mem_o;
    logic [3:0]  dest_o;

    logic        wb0, mr0, mw0;
    logic [31:0] alu0, val0;
    logic [3:0]  dest0;
    logic        stall0, wb_o0, mr_o0, ae_o0;
    logic [31:0] alu_o0, mem_o0;
    logic [3:0]  dest_o0;

    int checks = 0;
    int errors = 0;

    logic [31:0] mem_m [64];
    logic [31:0] memout_m;

    always #5 clk = ~clk;

    mem_stage_ws dut (
        .clk(clk), .rst(rst),
        .wbEnIn(wb), .memREnIn(mr), .memWEnIn(mw),
        .aluResIn(alu), .valRm(val), .destIn(dest),
        .stall(stall), .wbEnOut(wb_o), .memREnOut(mr_o),
        .aluResOut(alu_o), .memOut(mem_o), .destOut(dest_o), .alignErr(ae_o)
    );

    mem_stage_ws #(.WAIT_CYCLES(0)) dut0 (
        .clk(clk), .rst(rst),
        .wbEnIn(wb0), .memREnIn(mr0), .memWEnIn(mw0),
        .aluResIn(alu0), .valRm(val0), .destIn(dest0),
        .stall(stall0), .wbEnOut(wb_o0), .memREnOut(mr_o0),
        .aluResOut(alu_o0), .memOut(mem_o0), .destOut(dest_o0), .alignErr(ae_o0)
    );

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Word slot in the 64-word array for a byte address (wraps modulo 64).
    function automatic int unsigned idx_of(input logic [31:0] a);
        logic [31:0] off;
        off = a - 32'd1024;
        return (off / 4) % 64;
    endfunction

    task automatic clear_model();
        for (int i = 0; i < 64; i++) mem_m[i] = 32'h0;
        memout_m = 32'h0;
    endtask

    task automatic chk_zero_outputs(input string tag);
        chk({tag, ".stall"}, 64'(stall), 64'(0));
        chk({tag, ".wb"},    64'(wb_o),  64'(0));
        chk({tag, ".mr"},    64'(mr_o),  64'(0));
        chk({tag, ".alu"},   64'(alu_o), 64'(0));
        chk({tag, ".mem"},   64'(mem_o), 64'(0));
        chk({tag, ".dest"},  64'(dest_o), 64'(0));
        chk({tag, ".ae"},    64'(ae_o),  64'(0));
    endtask

    // Present one instruction to the 2-wait-state DUT and check the full
    // timeline: stall for two cycles, bubbles, then results on edge 3 (memory)
    // or edge 1 (ALU). Inputs are scrambled during WAIT to show they are ignored.
    task automatic do_op(input logic mr_i, input logic mw_i, input logic wb_i,
                         input logic [31:0] a, input logic [31:0] d,
                         input logic [3:0] dst, input string tag);
        int unsigned ix;
        logic [31:0] exp_mo;
        logic        exp_ae;
        logic        memop_i;
        memop_i = mr_i | mw_i;
        ix      = idx_of(a);
        exp_mo  = memout_m;
        if (mr_i) exp_mo = mem_m[ix];
        exp_ae  = memop_i && (a % 4 != 0);
        mr = mr_i; mw = mw_i; wb = wb_i; alu = a; val = d; dest = dst;
        #1;
        chk({tag, ".stallT"}, 64'(stall), 64'(memop_i));
        if (memop_i) begin
            step();
            chk({tag, ".bub1.wb"}, 64'(wb_o), 64'(0));
            chk({tag, ".bub1.mr"}, 64'(mr_o), 64'(0));
            chk({tag, ".bub1.ae"}, 64'(ae_o), 64'(0));
            wb = 1'($urandom); mr = 1'($urandom); mw = 1'($urandom);
            alu = $urandom; val = $urandom; dest = 4'($urandom);
            #1;
            chk({tag, ".stallT1"}, 64'(stall), 64'(1));
            step();
            chk({tag, ".bub2.wb"}, 64'(wb_o), 64'(0));
            chk({tag, ".bub2.mr"}, 64'(mr_o), 64'(0));
            chk({tag, ".stallT2"}, 64'(stall), 64'(0));
        end
        step();
        chk({tag, ".wb"},   64'(wb_o),   64'(wb_i));
        chk({tag, ".mr"},   64'(mr_o),   64'(mr_i));
        chk({tag, ".alu"},  64'(alu_o),  64'(a));
        chk({tag, ".dest"}, 64'(dest_o), 64'(dst));
        chk({tag, ".mem"},  64'(mem_o),  64'(exp_mo));
        chk({tag, ".ae"},   64'(ae_o),   64'(exp_ae));
        memout_m = exp_mo;
        if (mw_i) mem_m[ix] = d;
    endtask

    initial begin
        logic [31:0] vals0 [3];
        logic [31:0] ra;
        int          kind;

        rst = 1'b1;
        wb = 0; mr = 0; mw = 0; alu = 0; val = 0; dest = 0;
        wb0 = 0; mr0 = 0; mw0 = 0; alu0 = 0; val0 = 0; dest0 = 0;
        clear_model();

        #2 rst = 1'b0;
        #1;
        chk_zero_outputs("rst0");
        step();
        step();
        chk_zero_outputs("rst1");
        rst = 1'b1;

        // 1. Reset in the middle of a store aborts it and clears memory.
        do_op(0, 1, 0, 32'd1028, 32'hCAFE0001, 4'd0, "t1.pre");
        mr = 0; mw = 1; wb = 0; alu = 32'd1028; val = 32'h12345678; dest = 0;
        #1;
        chk("t1.stallT", 64'(stall), 64'(1));
        step();
        rst = 1'b0;
        #1;
        chk_zero_outputs("t1.rst");
        step();
        chk_zero_outputs("t1.rsthold");
        rst = 1'b1;
        clear_model();
        do_op(1, 0, 1, 32'd1028, 32'h0, 4'd2, "t1.load");

        // 2. Store then load.
        do_op(0, 1, 0, 32'd1032, 32'hDEADBEEF, 4'd0, "t2.st");
        do_op(1, 0, 1, 32'd1032, 32'h0, 4'd5, "t2.ld");

        // 3. ALU pass-through.
        do_op(0, 0, 1, 32'h55, 32'h0, 4'd3, "t3.alu");

        // 4. Wrap-around.
        do_op(0, 1, 0, 32'd1280, 32'hA5A5A5A5, 4'd0, "t4.st");
        do_op(1, 0, 1, 32'd1024, 32'h0, 4'd6, "t4.ld");

        // 5. Misaligned load, then load+store on one op.
        do_op(1, 0, 1, 32'd1026, 32'h0, 4'd7, "t5a.ld");
        do_op(0, 0, 1, 32'h99, 32'h0, 4'd8, "t5a.after");
        do_op(1, 1, 1, 32'd1024, 32'd7, 4'd9, "t5b.dual");
        do_op(1, 0, 1, 32'd1024, 32'h0, 4'd10, "t5b.ld");

        // Random mix of ALU ops, loads, stores and dual ops.
        for (int n = 0; n < 40; n++) begin
            kind = int'($urandom_range(0, 3));
            if ($urandom_range(0, 3) == 0) ra = $urandom;
            else                           ra = 32'd1024 + 32'($urandom_range(0, 1023));
            case (kind)
                0:       do_op(0, 0, 1'($urandom), ra, $urandom, 4'($urandom), "rnd.alu");
                1:       do_op(1, 0, 1'($urandom), ra, $urandom, 4'($urandom), "rnd.ld");
                2:       do_op(0, 1, 1'($urandom), ra, $urandom, 4'($urandom), "rnd.st");
                default: do_op(1, 1, 1'($urandom), ra, $urandom, 4'($urandom), "rnd.dual");
            endcase
        end
        mr = 0; mw = 0; wb = 0;

        // 6. Zero-wait-state build: back-to-back stores, then loads.
        vals0[0] = 32'h11111111;
        vals0[1] = 32'h22222222;
        vals0[2] = 32'h33333333;
        for (int i = 0; i < 3; i++) begin
            wb0 = 0; mr0 = 0; mw0 = 1; alu0 = 32'd1024 + 32'(4 * i); val0 = vals0[i]; dest0 = 0;
            #1;
            chk("t6.st.stall", 64'(stall0), 64'(0));
            step();
        end
        for (int i = 0; i < 3; i++) begin
            wb0 = 1; mr0 = 1; mw0 = 0; alu0 = 32'd1024 + 32'(4 * i); dest0 = 4'(i + 1);
            #1;
            chk("t6.ld.stall", 64'(stall0), 64'(0));
            step();
            chk("t6.ld.mem",  64'(mem_o0),  64'(vals0[i]));
            chk("t6.ld.dest", 64'(dest_o0), 64'(i + 1));
            chk("t6.ld.wb",   64'(wb_o0),   64'(1));
        end
        mr0 = 0; wb0 = 0;

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
